// File: rtl/micro_ctrl_alu_unit_pkg.sv
// Shared definitions for the microprogrammed control / ALU core of the multi-cycle MIPS CPU.
// Holds the control-word bit map, sequencing encodings, opcode/funct constants and the microcode ROM.
package micro_ctrl_alu_unit_pkg;

  localparam int WORD_W = 32;
  localparam int CTRL_W = 18;
  localparam int MPC_W  = 4;

  // Control-word bit positions (multi-bit fields give their LSB).
  localparam int CB_ADDR_LO      = 0;
  localparam int CB_PCWRITE      = 2;
  localparam int CB_PCWRITE_COND = 3;
  localparam int CB_PCSRC_LO     = 4;
  localparam int CB_IRWRITE      = 6;
  localparam int CB_MEMWRITE     = 7;
  localparam int CB_MEMREAD      = 8;
  localparam int CB_IORD         = 9;
  localparam int CB_REGWRITE     = 10;
  localparam int CB_MEMTOREG     = 11;
  localparam int CB_REGDST       = 12;
  localparam int CB_ALUSRCB_LO   = 13;
  localparam int CB_ALUSRCA      = 15;
  localparam int CB_ALUOP_LO     = 16;

  typedef enum logic [1:0] {
    ADDR_FETCH     = 2'd0,
    ADDR_DISPATCH1 = 2'd1,
    ADDR_DISPATCH2 = 2'd2,
    ADDR_NEXT      = 2'd3
  } addr_ctl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2,
    ALUOP_RSVD  = 2'd3
  } aluop_e;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_XOR  = 3'b011,
    ALU_NOR  = 3'b100,
    ALU_NONE = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  localparam logic [MPC_W-1:0] ST_FETCH    = 4'd0;
  localparam logic [MPC_W-1:0] ST_DECODE   = 4'd1;
  localparam logic [MPC_W-1:0] ST_MEMADDR  = 4'd2;
  localparam logic [MPC_W-1:0] ST_LW_READ  = 4'd3;
  localparam logic [MPC_W-1:0] ST_LW_WB    = 4'd4;
  localparam logic [MPC_W-1:0] ST_SW       = 4'd5;
  localparam logic [MPC_W-1:0] ST_R_EXEC   = 4'd6;
  localparam logic [MPC_W-1:0] ST_R_WB     = 4'd7;
  localparam logic [MPC_W-1:0] ST_BEQ      = 4'd8;
  localparam logic [MPC_W-1:0] ST_JUMP     = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Unused slots carry AddrCtl = fetch so a stray micro-PC always recovers.
  localparam logic [CTRL_W-1:0] UCODE [0:15] = '{
    18'h02147, 18'h06001, 18'h0C002, 18'h00303,
    18'h00C00, 18'h00280, 18'h28003, 18'h01400,
    18'h18018, 18'h00024, 18'h00000, 18'h00000,
    18'h00000, 18'h00000, 18'h00000, 18'h00000
  };

endpackage

// File: rtl/micro_ctrl_alu_unit_if.sv
// Instruction-field, operand and result bundle between the datapath and the control/ALU core.
interface micro_ctrl_alu_unit_if;
  import micro_ctrl_alu_unit_pkg::*;

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [WORD_W-1:0] alu_a;
  logic [WORD_W-1:0] alu_b;
  logic [CTRL_W-1:0] control;
  logic [MPC_W-1:0]  current_mpc;
  logic [WORD_W-1:0] alu_result;
  logic              zero;

  modport master (
    output opcode, funct, alu_a, alu_b,
    input  control, current_mpc, alu_result, zero
  );

  modport slave (
    input  opcode, funct, alu_a, alu_b,
    output control, current_mpc, alu_result, zero
  );
endinterface

// File: rtl/micro_ctrl_alu_unit_alu32.sv
// ALU-control decoder plus 32-bit combinational ALU; SLT compares as signed, ADD/SUB wrap.
module micro_alu32
  import micro_ctrl_alu_unit_pkg::*;
(
  input  aluop_e            alu_op,
  input  logic [5:0]        funct,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] result,
  output logic              zero
);

  alu_op_e op;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    op = ALU_ADD;
    unique case (alu_op)
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (funct)
          FN_SUB:  op = ALU_SUB;
          FN_AND:  op = ALU_AND;
          FN_OR:   op = ALU_OR;
          FN_SLT:  op = ALU_SLT;
          default: op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
  end

  always_comb begin
    result = '0;
    unique case (op)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {{(WORD_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/micro_ctrl_alu_unit.sv
// Microprogrammed control sequencer (micro-PC + ROM + dispatch) driving the ALU sub-block.
module micro_ctrl_alu_unit
  import micro_ctrl_alu_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  micro_ctrl_alu_unit_if.slave bus
);

  logic [MPC_W-1:0]  mpc;
  logic [MPC_W-1:0]  mpc_next;
  logic [CTRL_W-1:0] ctrl;
  addr_ctl_e         addr_ctl;
  aluop_e            alu_op;

  // NOTE: the ROM is a constant table, so it has no storage to reset; only the micro-PC is reset.
  assign ctrl     = UCODE[mpc];
  assign addr_ctl = addr_ctl_e'(ctrl[CB_ADDR_LO +: 2]);
  assign alu_op   = aluop_e'(ctrl[CB_ALUOP_LO +: 2]);

  always_comb begin
    mpc_next = ST_FETCH;
    unique case (addr_ctl)
      ADDR_NEXT: mpc_next = mpc + 4'd1;
      ADDR_DISPATCH1: begin
        unique case (bus.opcode)
          OP_RTYPE:     mpc_next = ST_R_EXEC;
          OP_J:         mpc_next = ST_JUMP;
          OP_BEQ:       mpc_next = ST_BEQ;
          OP_LW, OP_SW: mpc_next = ST_MEMADDR;
          default:      mpc_next = ST_FETCH;
        endcase
      end
      ADDR_DISPATCH2: begin
        unique case (bus.opcode)
          OP_LW:   mpc_next = ST_LW_READ;
          OP_SW:   mpc_next = ST_SW;
          default: mpc_next = ST_FETCH;
        endcase
      end
      default: mpc_next = ST_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mpc <= ST_FETCH;
    else      mpc <= mpc_next;
  end

  micro_alu32 u_alu (
    .alu_op (alu_op),
    .funct  (bus.funct),
    .a      (bus.alu_a),
    .b      (bus.alu_b),
    .result (bus.alu_result),
    .zero   (bus.zero)
  );

  assign bus.control     = ctrl;
  assign bus.current_mpc = mpc;

endmodule

// File: tb/tb_micro_ctrl_alu_unit.sv
// Self-checking bench: directed instruction walks, async reset, then randomized walks vs. a reference model.
module tb_micro_ctrl_alu_unit;

  typedef int path_t[$];

  localparam logic [17:0] EXP_CTRL [0:15] = '{
    18'h02147, 18'h06001, 18'h0C002, 18'h00303,
    18'h00C00, 18'h00280, 18'h28003, 18'h01400,
    18'h18018, 18'h00024, 18'h00000, 18'h00000,
    18'h00000, 18'h00000, 18'h00000, 18'h00000
  };

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  micro_ctrl_alu_unit_if bus ();

  micro_ctrl_alu_unit dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Micro-state sequence an instruction class visits, starting at fetch.
  function automatic path_t expected_path(input logic [5:0] op);
    path_t p;
    case (op)
      6'd35:   p = '{0, 1, 2, 3, 4};
      6'd43:   p = '{0, 1, 2, 5};
      6'd0:    p = '{0, 1, 6, 7};
      6'd4:    p = '{0, 1, 8};
      6'd2:    p = '{0, 1, 9};
      default: p = '{0, 1};
    endcase
    return p;
  endfunction

  // Arithmetic meaning of the instruction under a given ALUOp.
  function automatic logic [31:0] ref_alu(input logic [1:0] aluop, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = a + b;
    if (aluop == 2'd1) r = a - b;
    else if (aluop == 2'd2) begin
      case (fn)
        6'h22:   r = a - b;
        6'h24:   r = a & b;
        6'h25:   r = a | b;
        6'h2a:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: r = a + b;
      endcase
    end
    return r;
  endfunction

  // Runs one instruction from fetch; called at a falling edge with the micro-PC at 0.
  // Returns the ALU outputs seen in the third micro-state (execute / memaddr / beq).
  task automatic walk(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                      input logic [31:0] b, output logic [31:0] r2, output logic z2);
    path_t       path;
    logic [17:0] ec;
    logic [31:0] er;
    path = expected_path(op);
    bus.opcode = op;
    bus.funct  = fn;
    bus.alu_a  = a;
    bus.alu_b  = b;
    r2 = '0;
    z2 = 1'b0;
    for (int i = 0; i < path.size(); i++) begin
      #1;
      ec = EXP_CTRL[path[i]];
      er = ref_alu(ec[17:16], fn, a, b);
      check("mpc", {28'd0, bus.current_mpc}, path[i]);
      check("control", {14'd0, bus.control}, {14'd0, ec});
      check("alu_result", bus.alu_result, er);
      check("zero", {31'd0, bus.zero}, {31'd0, (er == 32'd0)});
      if (i == 2) begin
        r2 = bus.alu_result;
        z2 = bus.zero;
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic        z;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    vectors     = 0;
    miscompares = 0;
    rst_n      = 1'b0;
    bus.opcode = 6'd35;
    bus.funct  = 6'h20;
    bus.alu_a  = '0;
    bus.alu_b  = '0;

    // Reset held with clock running.
    repeat (3) @(negedge clk);
    #1;
    check("reset_mpc", {28'd0, bus.current_mpc}, 32'd0);
    check("reset_control", {14'd0, bus.control}, 32'h02147);
    rst_n = 1'b1;

    // lw, sw, R-type walks.
    walk(6'd35, 6'h20, $urandom, $urandom, r, z);
    walk(6'd43, 6'h20, $urandom, $urandom, r, z);
    walk(6'd0, 6'h22, 32'd5, 32'd5, r, z);
    check("rsub_eq_result", r, 32'd0);
    check("rsub_eq_zero", {31'd0, z}, 32'd1);
    walk(6'd0, 6'h22, 32'd3, 32'd5, r, z);
    check("rsub_neg_result", r, 32'hFFFF_FFFE);
    check("rsub_neg_zero", {31'd0, z}, 32'd0);

    // beq (subtract regardless of funct), jump, unknown opcode.
    walk(6'd4, 6'h25, 32'd9, 32'd4, r, z);
    check("beq_sub", r, 32'd5);
    walk(6'd2, 6'h20, $urandom, $urandom, r, z);
    walk(6'h3F, 6'h20, $urandom, $urandom, r, z);

    // Function decode under ALUOp 10.
    walk(6'd0, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, r, z);
    check("and", r, 32'hF000_F000);
    walk(6'd0, 6'h25, 32'hF0F0_F0F0, 32'hFF00_FF00, r, z);
    check("or", r, 32'hFFF0_FFF0);
    walk(6'd0, 6'h2a, 32'hFFFF_FFFF, 32'd1, r, z);
    check("slt_signed", r, 32'd1);
    walk(6'd0, 6'h20, 32'hFFFF_FFFF, 32'd1, r, z);
    check("add_wrap", r, 32'd0);
    check("add_wrap_zero", {31'd0, z}, 32'd1);

    // Async reset while in R writeback, between edges.
    bus.opcode = 6'd0;
    bus.funct  = 6'h20;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    check("pre_reset_mpc", {28'd0, bus.current_mpc}, 32'd7);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_mpc", {28'd0, bus.current_mpc}, 32'd0);
    check("async_reset_control", {14'd0, bus.control}, 32'h02147);
    @(posedge clk);
    @(negedge clk);
    check("reset_hold_mpc", {28'd0, bus.current_mpc}, 32'd0);
    rst_n = 1'b1;
    walk(6'd35, 6'h20, $urandom, $urandom, r, z);

    // Randomized instruction walks.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       op = 6'd0;
        1:       op = 6'd2;
        2:       op = 6'd4;
        3:       op = 6'd35;
        4:       op = 6'd43;
        default: op = 6'($urandom_range(0, 63));
      endcase
      case ($urandom_range(0, 5))
        0:       fn = 6'h20;
        1:       fn = 6'h22;
        2:       fn = 6'h24;
        3:       fn = 6'h25;
        4:       fn = 6'h2a;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      walk(op, fn, a, b, r, z);
    end

    #1;
    check("final_mpc", {28'd0, bus.current_mpc}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
